camera_capture: RTL and testbench

CAMERA_CAPTURE -- requirements
Module: camera_capture

---
 rtl/camera_capture.sv | 176 +++++++++++++++++
 tb/tb_camera_capture.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture.sv
// camera_capture
//   Captures pixels from a parallel 8-bit camera interface (OV76xx-style
//   VSYNC/HREF/PCLK timing). Bytes qualified by href_in are packed into
//   BYTES_PER_PIXEL-byte pixels, with the first byte landing in the MSBs.
//   Every completed pixel is presented for one cycle together with its
//   column and row. Capture only starts after a full vsync high-then-low
//   sequence, so a frame is never picked up half way through.
//
//   Optional feature: define CAMERA_LINE_CHECK_EN to add line_err_out, a
//   one-cycle pulse at the end of any line whose pixel count differs from
//   H_ACTIVE or which ended with a partial pixel.
//
// Ports
//   p_clock_in      camera pixel clock, the only clock (rising edge)
//   rst_in          asynchronous active-high reset
//   vsync_in        frame sync, high = inter-frame blanking
//   href_in         line-valid qualifier for p_data_in
//   p_data_in       camera byte bus
//   pixel_data_out  assembled pixel, held between strobes
//   pixel_valid_out one-cycle strobe for pixel_data_out/hcount_out/vcount_out
//   hcount_out      pixel column, saturates at H_ACTIVE
//   vcount_out      pixel row, saturates at V_ACTIVE
//   frame_done_out  one-cycle end-of-frame pulse
//   line_err_out    one-cycle line-length error pulse (CAMERA_LINE_CHECK_EN)

module camera_capture #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int H_ACTIVE        = 320,
    parameter int V_ACTIVE        = 240
) (
    input  logic                               p_clock_in,
    input  logic                               rst_in,
    input  logic                               vsync_in,
    input  logic                               href_in,
    input  logic [7:0]                         p_data_in,
    output logic [8*BYTES_PER_PIXEL-1:0]       pixel_data_out,
    output logic                               pixel_valid_out,
    output logic [$clog2(H_ACTIVE+1)-1:0]      hcount_out,
    output logic [$clog2(V_ACTIVE+1)-1:0]      vcount_out,
    output logic                               frame_done_out
`ifdef CAMERA_LINE_CHECK_EN
    ,
    output logic                               line_err_out
`endif
);

    localparam int PW = 8 * BYTES_PER_PIXEL;
    localparam int HW = $clog2(H_ACTIVE + 1);
    localparam int VW = $clog2(V_ACTIVE + 1);

    localparam logic [HW-1:0] H_MAX    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_MAX    = VW'(V_ACTIVE);
    localparam logic [1:0]    LAST_IDX = 2'(BYTES_PER_PIXEL - 1);

    typedef enum logic [1:0] {
        SYNC       = 2'd0,
        WAIT_START = 2'd1,
        CAPTURE    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      byte_idx_q;
    logic [HW-1:0]   col_q;
    logic [VW-1:0]   row_q;
    logic [PW-1:0]   asm_q, asm_next;
    logic            href_q;       // href_in as accepted last cycle in CAPTURE
`ifdef CAMERA_LINE_CHECK_EN
    logic            col_ovf_q;    // more than H_ACTIVE pixels on this line
`endif

    logic            frame_end, take_byte, line_fall, last_byte;

    // Next-state and per-cycle control decode.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        frame_end = 1'b0;
        take_byte = 1'b0;
        line_fall = 1'b0;
        unique case (state_q)
            SYNC:       if (vsync_in)  state_d = WAIT_START;
            WAIT_START: if (!vsync_in) state_d = CAPTURE;
            CAPTURE: begin
                if (vsync_in) begin
                    // vsync wins over a simultaneous href byte
                    state_d   = WAIT_START;
                    frame_end = 1'b1;
                end else begin
                    take_byte = href_in;
                    line_fall = href_q && !href_in;
                end
            end
            default:    state_d = SYNC;
        endcase
    end

    assign last_byte = (byte_idx_q == LAST_IDX);

    // Drop the incoming byte into its slot; byte 0 goes to the MSBs.
    always_comb begin
        asm_next = asm_q;
        for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
            if (byte_idx_q == 2'(k))
                asm_next[8*(BYTES_PER_PIXEL-k)-1 -: 8] = p_data_in;
        end
    end

    always_ff @(posedge p_clock_in or posedge rst_in) begin
        if (rst_in) begin
            state_q         <= SYNC;
            byte_idx_q      <= '0;
            col_q           <= '0;
            row_q           <= '0;
            asm_q           <= '0;
            href_q          <= 1'b0;
            pixel_data_out  <= '0;
            pixel_valid_out <= 1'b0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            frame_done_out  <= 1'b0;
`ifdef CAMERA_LINE_CHECK_EN
            col_ovf_q       <= 1'b0;
            line_err_out    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge values.
            state_q         <= state_d;
            href_q          <= take_byte;
            pixel_valid_out <= 1'b0;
            frame_done_out  <= 1'b0;
`ifdef CAMERA_LINE_CHECK_EN
            line_err_out    <= 1'b0;
`endif
            if (frame_end) begin
                // Partial pixel is dropped simply by clearing the byte index.
                byte_idx_q     <= '0;
                col_q          <= '0;
                row_q          <= '0;
                hcount_out     <= '0;
                vcount_out     <= '0;
                frame_done_out <= 1'b1;
`ifdef CAMERA_LINE_CHECK_EN
                col_ovf_q      <= 1'b0;
`endif
            end else if (line_fall) begin
                byte_idx_q <= '0;
                col_q      <= '0;
                // A non-zero column means at least one pixel completed.
                if (col_q != '0 && row_q != V_MAX)
                    row_q <= row_q + 1'b1;
`ifdef CAMERA_LINE_CHECK_EN
                col_ovf_q    <= 1'b0;
                line_err_out <= (col_q != H_MAX) || col_ovf_q || (byte_idx_q != '0);
`endif
            end else if (take_byte) begin
                asm_q <= asm_next;
                if (last_byte) begin
                    byte_idx_q      <= '0;
                    pixel_data_out  <= asm_next;
                    pixel_valid_out <= 1'b1;
                    hcount_out      <= col_q;
                    vcount_out      <= row_q;
                    if (col_q != H_MAX)
                        col_q <= col_q + 1'b1;
`ifdef CAMERA_LINE_CHECK_EN
                    else
                        col_ovf_q <= 1'b1;
`endif
                end else begin
                    byte_idx_q <= byte_idx_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// Testbench for camera_capture. Two instances share one camera stream:
// u_p2 (2 bytes/pixel) and u_p3 (3 bytes/pixel), both H_ACTIVE=4,
// V_ACTIVE=3 so column and row saturation are reached. Expected pixels are
// derived per line from the byte list: pixel j = bytes j*B..j*B+B-1,
// column min(j,H), row min(lines-with-pixels-so-far,V).

module tb_camera_capture;

    localparam int H = 4;
    localparam int V = 3;

    typedef struct {
        logic [31:0] data;
        int          h;
        int          v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  data = 8'h00;

    logic [15:0] p2_data;
    logic        p2_valid, p2_fd;
    logic [2:0]  p2_h;
    logic [1:0]  p2_v;
    logic [23:0] p3_data;
    logic        p3_valid, p3_fd;
    logic [2:0]  p3_h;
    logic [1:0]  p3_v;
`ifdef CAMERA_LINE_CHECK_EN
    logic        p2_err, p3_err;
`endif

    camera_capture #(.BYTES_PER_PIXEL(2), .H_ACTIVE(H), .V_ACTIVE(V)) u_p2 (
        .p_clock_in(clk), .rst_in(rst), .vsync_in(vsync), .href_in(href),
        .p_data_in(data), .pixel_data_out(p2_data), .pixel_valid_out(p2_valid),
        .hcount_out(p2_h), .vcount_out(p2_v), .frame_done_out(p2_fd)
`ifdef CAMERA_LINE_CHECK_EN
        , .line_err_out(p2_err)
`endif
    );

    camera_capture #(.BYTES_PER_PIXEL(3), .H_ACTIVE(H), .V_ACTIVE(V)) u_p3 (
        .p_clock_in(clk), .rst_in(rst), .vsync_in(vsync), .href_in(href),
        .p_data_in(data), .pixel_data_out(p3_data), .pixel_valid_out(p3_valid),
        .hcount_out(p3_h), .vcount_out(p3_v), .frame_done_out(p3_fd)
`ifdef CAMERA_LINE_CHECK_EN
        , .line_err_out(p3_err)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    exp_t        q2[$], q3[$];
    exp_t        e2, e3;
    logic [7:0]  line_bytes[$];
    int          row[2];
    int          exp_err[2];
    int          err_cnt[2];
    int          fd_cnt[2];
    int          exp_fd = 0;
    bit          in_cap = 1'b0;
    bit          seen_high = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int bpp_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    // Expected pixels / line errors for the bytes in line_bytes.
    task automatic model_line(input bit ends_with_fall);
        for (int d = 0; d < 2; d++) begin
            int b;
            int np;
            int rem;
            b   = bpp_of(d);
            np  = line_bytes.size() / b;
            rem = line_bytes.size() % b;
            for (int j = 0; j < np; j++) begin
                exp_t e;
                e.data = '0;
                for (int k = 0; k < b; k++)
                    e.data = (e.data << 8) | 32'(line_bytes[j*b+k]);
                e.h = (j < H) ? j : H;
                e.v = (row[d] < V) ? row[d] : V;
                if (d == 0) q2.push_back(e);
                else        q3.push_back(e);
            end
            if (np > 0) row[d]++;
            if (ends_with_fall && (np != H || rem != 0)) exp_err[d]++;
        end
    endtask

    // vsync high for n cycles; href toggles randomly and must be ignored.
    task automatic blank(input int n, input bit href_first);
        if (in_cap) exp_fd++;
        in_cap    = 1'b0;
        seen_high = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vsync = 1'b1;
            href  = (i == 0) ? href_first : 1'($urandom_range(0, 1));
            data  = 8'($urandom);
        end
    endtask

    task automatic start_body();
        repeat (2) begin
            @(negedge clk);
            vsync = 1'b0;
            href  = 1'b0;
            data  = 8'($urandom);
        end
        if (seen_high) in_cap = 1'b1;
        row[0] = 0;
        row[1] = 0;
    endtask

    // Send line_bytes under href; gap=0 leaves href high for the caller's vsync.
    task automatic send_line(input int gap);
        model_line(gap > 0);
        foreach (line_bytes[i]) begin
            @(negedge clk);
            vsync = 1'b0;
            href  = 1'b1;
            data  = line_bytes[i];
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            href = 1'b0;
            data = 8'($urandom);
        end
    endtask

    task automatic fill_random(input int n);
        line_bytes.delete();
        for (int i = 0; i < n; i++) line_bytes.push_back(8'($urandom));
    endtask

    task automatic random_frame();
        int  nl;
        bit  sim_end;
        nl      = $urandom_range(1, 5);
        sim_end = ($urandom_range(0, 3) == 0);
        blank($urandom_range(2, 5), 1'($urandom_range(0, 1)));
        start_body();
        for (int l = 0; l < nl; l++) begin
            fill_random($urandom_range(1, 14));
            send_line((sim_end && l == nl - 1) ? 0 : $urandom_range(1, 3));
        end
    endtask

    task automatic check_reset_outputs(input string when);
        check({when, " p2 data"},  32'(p2_data),  32'd0);
        check({when, " p2 valid"}, 32'(p2_valid), 32'd0);
        check({when, " p2 h"},     32'(p2_h),     32'd0);
        check({when, " p2 v"},     32'(p2_v),     32'd0);
        check({when, " p2 fd"},    32'(p2_fd),    32'd0);
        check({when, " p3 data"},  32'(p3_data),  32'd0);
        check({when, " p3 valid"}, 32'(p3_valid), 32'd0);
`ifdef CAMERA_LINE_CHECK_EN
        check({when, " p2 err"},   32'(p2_err),   32'd0);
`endif
    endtask

    // Strobe scoreboards and pulse counters.
    always @(negedge clk) begin
        if (!rst && p2_valid) begin
            if (q2.size() == 0) begin
                check("p2 unexpected_strobe", 32'(p2_valid), 32'd0);
            end else begin
                e2 = q2.pop_front();
                check("p2 data", 32'(p2_data), e2.data);
                check("p2 hcount", 32'(p2_h), 32'(e2.h));
                check("p2 vcount", 32'(p2_v), 32'(e2.v));
            end
        end
        if (!rst && p3_valid) begin
            if (q3.size() == 0) begin
                check("p3 unexpected_strobe", 32'(p3_valid), 32'd0);
            end else begin
                e3 = q3.pop_front();
                check("p3 data", 32'(p3_data), e3.data);
                check("p3 hcount", 32'(p3_h), 32'(e3.h));
                check("p3 vcount", 32'(p3_v), 32'(e3.v));
            end
        end
        if (p2_fd) fd_cnt[0]++;
        if (p3_fd) fd_cnt[1]++;
`ifdef CAMERA_LINE_CHECK_EN
        if (p2_err) err_cnt[0]++;
        if (p3_err) err_cnt[1]++;
`endif
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            row[d] = 0; exp_err[d] = 0; err_cnt[d] = 0; fd_cnt[d] = 0;
        end

        // Reset with href wiggling; outputs must be cleared.
        repeat (3) begin
            @(negedge clk);
            href = 1'($urandom_range(0, 1));
            data = 8'($urandom);
        end
        check_reset_outputs("reset");
        @(negedge clk);
        rst  = 1'b0;
        href = 1'b1;
        // href before any vsync: SYNC must ignore it.
        repeat (4) begin
            @(negedge clk);
            data = 8'($urandom);
        end

        // Frame 1: directed lines.
        blank(3, 1'b0);
        start_body();
        line_bytes = '{8'hA1, 8'hB2};
        send_line(2);
        line_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        send_line(2);
        line_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send_line(1);

        // Frame 2: three lines, then vsync and href rise together mid-pixel.
        blank(4, 1'b0);
        start_body();
        for (int l = 0; l < 3; l++) begin
            fill_random(8);
            send_line(2);
        end
        fill_random(3);
        send_line(0);
        blank(3, 1'b1);

        // Frame 3: starts clean after the dropped partial pixel.
        start_body();
        fill_random(6);
        send_line(1);
        fill_random(12);
        send_line(3);

        for (int f = 0; f < 4; f++) random_frame();

        // Reset in the middle of a line with a partial pixel pending.
        blank(2, 1'b0);
        start_body();
        @(negedge clk);
        href = 1'b1;
        data = 8'h5A;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        in_cap    = 1'b0;
        seen_high = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // Rest of the interrupted frame: nothing may come out.
        for (int l = 0; l < 3; l++) begin
            repeat (9) begin
                @(negedge clk);
                href = 1'b1;
                data = 8'($urandom);
            end
            @(negedge clk);
            href = 1'b0;
        end

        for (int f = 0; f < 8; f++) random_frame();
        blank(3, 1'b0);
        repeat (5) @(negedge clk);

        check("p2 pending_pixels", q2.size(), 0);
        check("p3 pending_pixels", q3.size(), 0);
        check("p2 frame_done_cycles", fd_cnt[0], exp_fd);
        check("p3 frame_done_cycles", fd_cnt[1], exp_fd);
`ifdef CAMERA_LINE_CHECK_EN
        check("p2 line_err_pulses", err_cnt[0], exp_err[0]);
        check("p3 line_err_pulses", err_cnt[1], exp_err[1]);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
